// File: rtl/ch_eqlz_zf_if.sv
`timescale 1ns/1ps
// Stream bundle of ch_eqlz_zf: channel-estimate pairs and data REs in,
// equalized REs with CSI weight out.
interface ch_eqlz_zf_if #(
  parameter int WIDTH_RX  = 16,
  parameter int H_WIDTH   = 17,
  parameter int OUT_WIDTH = 16,
  parameter int CSI_WIDTH = 16
);
  logic signed [H_WIDTH-1:0]   h_eqlz_1_r;
  logic signed [H_WIDTH-1:0]   h_eqlz_1_i;
  logic signed [H_WIDTH-1:0]   h_eqlz_2_r;
  logic signed [H_WIDTH-1:0]   h_eqlz_2_i;
  logic                        valid_eqlz;
  logic signed [WIDTH_RX-1:0]  rx_r;
  logic signed [WIDTH_RX-1:0]  rx_i;
  logic [3:0]                  rx_sc;
  logic                        rx_valid;
  logic                        rx_last;
  logic                        eq_ready;
  logic signed [OUT_WIDTH-1:0] eq_r;
  logic signed [OUT_WIDTH-1:0] eq_i;
  logic [CSI_WIDTH-1:0]        csi;
  logic                        eq_valid;
  logic                        eq_last;
  logic                        sc_err;
  logic                        est_overrun;

  modport master (
    output h_eqlz_1_r, h_eqlz_1_i, h_eqlz_2_r, h_eqlz_2_i, valid_eqlz,
    output rx_r, rx_i, rx_sc, rx_valid, rx_last,
    input  eq_ready, eq_r, eq_i, csi, eq_valid, eq_last, sc_err, est_overrun
  );

  modport slave (
    input  h_eqlz_1_r, h_eqlz_1_i, h_eqlz_2_r, h_eqlz_2_i, valid_eqlz,
    input  rx_r, rx_i, rx_sc, rx_valid, rx_last,
    output eq_ready, eq_r, eq_i, csi, eq_valid, eq_last, sc_err, est_overrun
  );
endinterface

// File: rtl/ch_eqlz_zf.sv
`timescale 1ns/1ps
// One-tap zero-forcing style equalizer: buffers 12 subcarrier estimates, then
// multiplies each data RE by conj(h) and emits a rounded/saturated result with |h|^2.
module ch_eqlz_zf #(
  parameter int WIDTH_RX  = 16,
  parameter int H_WIDTH   = 17,
  parameter int OUT_WIDTH = 16,
  parameter int CSI_WIDTH = 16,
  parameter int EQ_SHIFT  = 16,
  parameter int CSI_SHIFT = 16
) (
  input logic         clk,
  input logic         rst,
  ch_eqlz_zf_if.slave bus
);
  localparam int PW  = WIDTH_RX + H_WIDTH;
  localparam int SW  = PW + 1;
  localparam int HW2 = 2 * H_WIDTH;
  localparam int CW  = HW2 + 1;

  localparam logic signed [SW:0] EQ_HALF = (SW+1)'(1) <<< (EQ_SHIFT - 1);
  localparam logic signed [SW:0] OUT_MAX = (SW+1)'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [SW:0] OUT_MIN = ~OUT_MAX;
  localparam logic [CW:0]        CSI_HALF = (CW+1)'(1) << (CSI_SHIFT - 1);
  localparam logic [CW:0]        CSI_MAX  = (CW+1)'({CSI_WIDTH{1'b1}});

  function automatic logic signed [OUT_WIDTH-1:0] rnd_sat_eq(input logic signed [SW-1:0] x);
    logic signed [SW:0] t;
    t = (SW+1)'(x) + EQ_HALF;
    t = t >>> EQ_SHIFT;
    if (t > OUT_MAX)      return OUT_MAX[OUT_WIDTH-1:0];
    else if (t < OUT_MIN) return OUT_MIN[OUT_WIDTH-1:0];
    else                  return t[OUT_WIDTH-1:0];
  endfunction

  function automatic logic [CSI_WIDTH-1:0] rnd_sat_csi(input logic [CW-1:0] x);
    logic [CW:0] t;
    t = (CW+1)'(x) + CSI_HALF;
    t = t >> CSI_SHIFT;
    if (t > CSI_MAX) return '1;
    else             return t[CSI_WIDTH-1:0];
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, EQ} state_t;

  state_t     state, state_nxt;
  logic [2:0] wr_cnt, wr_cnt_nxt;

  logic signed [H_WIDTH-1:0] hb_r [0:11];
  logic signed [H_WIDTH-1:0] hb_i [0:11];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      wr_cnt <= '0;
    end else begin
      state  <= state_nxt;
      wr_cnt <= wr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    case (state)
      IDLE: if (bus.valid_eqlz) begin
        state_nxt  = LOAD;
        wr_cnt_nxt = 3'd1;
      end
      LOAD: if (bus.valid_eqlz) begin
        if (wr_cnt == 3'd5) begin
          state_nxt  = EQ;
          wr_cnt_nxt = '0;
        end else begin
          wr_cnt_nxt = wr_cnt + 3'd1;
        end
      end
      EQ: if (bus.rx_valid && bus.rx_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pairs arriving while equalizing are dropped and flagged instead of written.
  logic       wr_en;
  logic [2:0] wr_pair;
  logic       acc;
  assign wr_en   = bus.valid_eqlz && (state != EQ);
  assign wr_pair = (state == IDLE) ? 3'd0 : wr_cnt;
  assign acc     = bus.rx_valid && (state == EQ);
  assign bus.eq_ready = (state == EQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 12; k++) begin
        hb_r[k] <= '0;
        hb_i[k] <= '0;
      end
    end else if (wr_en) begin
      hb_r[{wr_pair, 1'b0}] <= bus.h_eqlz_1_r;
      hb_i[{wr_pair, 1'b0}] <= bus.h_eqlz_1_i;
      hb_r[{wr_pair, 1'b1}] <= bus.h_eqlz_2_r;
      hb_i[{wr_pair, 1'b1}] <= bus.h_eqlz_2_i;
    end
  end

  // An out-of-range subcarrier selects h=0, which forces zero data and CSI.
  logic                      sc_ok;
  logic signed [H_WIDTH-1:0] h_sel_r, h_sel_i;
  assign sc_ok   = (bus.rx_sc <= 4'd11);
  assign h_sel_r = sc_ok ? hb_r[bus.rx_sc] : '0;
  assign h_sel_i = sc_ok ? hb_i[bus.rx_sc] : '0;

  // Stage p0: registered products
  logic                 vld_p0, last_p0, err_p0;
  logic signed [PW-1:0] pr_rr_p0, pr_ii_p0, pr_ir_p0, pr_ri_p0;
  logic [HW2-1:0]       hr2_p0, hi2_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
      err_p0   <= 1'b0;
      pr_rr_p0 <= '0;
      pr_ii_p0 <= '0;
      pr_ir_p0 <= '0;
      pr_ri_p0 <= '0;
      hr2_p0   <= '0;
      hi2_p0   <= '0;
    end else begin
      vld_p0  <= acc;
      last_p0 <= acc && bus.rx_last;
      err_p0  <= acc && !sc_ok;
      if (acc) begin
        pr_rr_p0 <= PW'(bus.rx_r) * PW'(h_sel_r);
        pr_ii_p0 <= PW'(bus.rx_i) * PW'(h_sel_i);
        pr_ir_p0 <= PW'(bus.rx_i) * PW'(h_sel_r);
        pr_ri_p0 <= PW'(bus.rx_r) * PW'(h_sel_i);
        hr2_p0   <= HW2'(h_sel_r) * HW2'(h_sel_r);
        hi2_p0   <= HW2'(h_sel_i) * HW2'(h_sel_i);
      end
    end
  end

  // Stage p1: sum, round, saturate
  logic signed [SW-1:0] sum_re, sum_im;
  logic [CW-1:0]        sum_csi;
  assign sum_re  = SW'(pr_rr_p0) + SW'(pr_ii_p0);
  assign sum_im  = SW'(pr_ir_p0) - SW'(pr_ri_p0);
  assign sum_csi = CW'(hr2_p0) + CW'(hi2_p0);

  logic                        vld_p1, last_p1, err_p1, ovr_p1;
  logic signed [OUT_WIDTH-1:0] eq_r_p1, eq_i_p1;
  logic [CSI_WIDTH-1:0]        csi_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      err_p1  <= 1'b0;
      ovr_p1  <= 1'b0;
      eq_r_p1 <= '0;
      eq_i_p1 <= '0;
      csi_p1  <= '0;
    end else begin
      vld_p1  <= vld_p0;
      last_p1 <= vld_p0 && last_p0;
      err_p1  <= vld_p0 && err_p0;
      ovr_p1  <= bus.valid_eqlz && (state == EQ);
      if (vld_p0) begin
        eq_r_p1 <= rnd_sat_eq(sum_re);
        eq_i_p1 <= rnd_sat_eq(sum_im);
        csi_p1  <= rnd_sat_csi(sum_csi);
      end
    end
  end

  assign bus.eq_valid    = vld_p1;
  assign bus.eq_last     = last_p1;
  assign bus.sc_err      = err_p1;
  assign bus.est_overrun = ovr_p1;
  assign bus.eq_r        = eq_r_p1;
  assign bus.eq_i        = eq_i_p1;
  assign bus.csi         = csi_p1;
endmodule

// File: tb/tb_ch_eqlz_zf.sv
`timescale 1ns/1ps
// Bench for ch_eqlz_zf: directed literal cases plus randomized traffic checked
// every cycle against a behavioural model of the equalizer.
module tb_ch_eqlz_zf;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ch_eqlz_zf_if bus ();
  ch_eqlz_zf dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_hr [12];
  int     m_hi [12];
  int     m_n;
  bit     m_eq;
  bit     s_vld, s_last, s_err;
  longint s_r, s_i, s_csi;
  bit     o_vld, o_last, o_err, o_ovr;
  longint o_r, o_i, o_csi;
  bit     cur_eq;
  int     sc;
  longint hr, hi, xr, xi;

  function automatic longint rnd_sat(input longint v, input longint lo, input longint hi_lim);
    longint t;
    t = (v + 64'sd32768) >>> 16;
    if (t < lo) return lo;
    if (t > hi_lim) return hi_lim;
    return t;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      for (int k = 0; k < 12; k++) begin
        m_hr[k] = 0;
        m_hi[k] = 0;
      end
      m_n = 0; m_eq = 0;
      s_vld = 0; s_last = 0; s_err = 0; s_r = 0; s_i = 0; s_csi = 0;
      o_vld = 0; o_last = 0; o_err = 0; o_ovr = 0; o_r = 0; o_i = 0; o_csi = 0;
    end else begin
      cur_eq = m_eq;
      o_vld  = s_vld;
      o_last = s_vld & s_last;
      o_err  = s_vld & s_err;
      if (s_vld) begin
        o_r = s_r; o_i = s_i; o_csi = s_csi;
      end
      o_ovr = bus.valid_eqlz & cur_eq;
      s_vld = bus.rx_valid & cur_eq;
      s_last = 0; s_err = 0;
      if (s_vld) begin
        sc     = int'(bus.rx_sc);
        s_last = bus.rx_last;
        s_err  = (sc > 11);
        if (sc > 11) begin
          s_r = 0; s_i = 0; s_csi = 0;
        end else begin
          hr = m_hr[sc]; hi = m_hi[sc];
          xr = bus.rx_r;  xi = bus.rx_i;
          s_r   = rnd_sat(xr * hr + xi * hi, -32768, 32767);
          s_i   = rnd_sat(xi * hr - xr * hi, -32768, 32767);
          s_csi = rnd_sat(hr * hr + hi * hi, 0, 65535);
        end
      end
      if (!cur_eq && bus.valid_eqlz) begin
        m_hr[2*m_n]   = bus.h_eqlz_1_r;
        m_hi[2*m_n]   = bus.h_eqlz_1_i;
        m_hr[2*m_n+1] = bus.h_eqlz_2_r;
        m_hi[2*m_n+1] = bus.h_eqlz_2_i;
        m_n++;
        if (m_n == 6) begin
          m_eq = 1; m_n = 0;
        end
      end
      if (cur_eq && bus.rx_valid && bus.rx_last) m_eq = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("eq_ready",    bus.eq_ready,    m_eq);
    chk("est_overrun", bus.est_overrun, o_ovr);
    chk("eq_valid",    bus.eq_valid,    o_vld);
    chk("eq_last",     bus.eq_last,     o_last);
    chk("sc_err",      bus.sc_err,      o_err);
    chk("eq_r",        bus.eq_r,        o_r);
    chk("eq_i",        bus.eq_i,        o_i);
    chk("csi",         bus.csi,         o_csi);
  end

  // ---------------- stimulus helpers ----------------
  int hr_t [12];
  int hi_t [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.h_eqlz_1_r = '0; bus.h_eqlz_1_i = '0;
    bus.h_eqlz_2_r = '0; bus.h_eqlz_2_i = '0;
    bus.valid_eqlz = 1'b0;
    bus.rx_r = '0; bus.rx_i = '0; bus.rx_sc = '0;
    bus.rx_valid = 1'b0; bus.rx_last = 1'b0;
  endtask

  task automatic fill_h(input int r, input int i);
    for (int k = 0; k < 12; k++) begin
      hr_t[k] = r;
      hi_t[k] = i;
    end
  endtask

  task automatic load_all(input int gap);
    for (int k = 0; k < 6; k++) begin
      bus.h_eqlz_1_r = 17'(hr_t[2*k]);
      bus.h_eqlz_1_i = 17'(hi_t[2*k]);
      bus.h_eqlz_2_r = 17'(hr_t[2*k+1]);
      bus.h_eqlz_2_i = 17'(hi_t[2*k+1]);
      bus.valid_eqlz = 1'b1;
      tick();
      bus.valid_eqlz = 1'b0;
      chk("load_ready", bus.eq_ready, (k == 5) ? 1 : 0);
      if (k < 5) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("gap_ready", bus.eq_ready, 0);
        end
      end
    end
  endtask

  task automatic send_re(input int r, input int i, input int s, input bit last);
    bus.rx_r = 16'(r); bus.rx_i = 16'(i); bus.rx_sc = 4'(s);
    bus.rx_last = last; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0; bus.rx_last = 1'b0;
  endtask

  function automatic logic [16:0] rand_h();
    case ($urandom_range(0, 9))
      0: return 17'h10000;
      1: return 17'h0FFFF;
      default: return 17'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] rand_rx();
    case ($urandom_range(0, 9))
      0: return 16'h8000;
      1: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    drive_idle();
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_ready", bus.eq_ready, 0);
    chk("rst_valid", bus.eq_valid, 0);
    chk("rst_eq_r",  bus.eq_r, 0);
    chk("rst_csi",   bus.csi, 0);
    chk("rst_ovr",   bus.est_overrun, 0);
    rst = 1'b1;
    tick();

    // unit real channel
    fill_h(16384, 0);
    load_all(0);
    send_re(1000, -2000, 3, 1'b1);
    tick();
    chk("t1_eq_r",  bus.eq_r, 250);
    chk("t1_eq_i",  bus.eq_i, -500);
    chk("t1_csi",   bus.csi, 4096);
    chk("t1_valid", bus.eq_valid, 1);
    chk("t1_last",  bus.eq_last, 1);
    tick();
    chk("t1_valid_drop", bus.eq_valid, 0);
    chk("t1_hold_r",     bus.eq_r, 250);

    // imaginary channel on subcarrier 5
    fill_h(16384, 0);
    hr_t[5] = 0; hi_t[5] = 16384;
    load_all(0);
    send_re(1000, 0, 5, 1'b1);
    tick();
    chk("t2_eq_r", bus.eq_r, 0);
    chk("t2_eq_i", bus.eq_i, -250);
    chk("t2_csi",  bus.csi, 4096);

    // saturation on both data and CSI
    fill_h(65535, 65535);
    load_all(0);
    send_re(-32768, -32768, 0, 1'b1);
    tick();
    chk("t3_eq_r", bus.eq_r, -32768);
    chk("t3_eq_i", bus.eq_i, 0);
    chk("t3_csi",  bus.csi, 65535);

    // gapped load then out-of-range subcarrier
    fill_h(16384, 0);
    load_all(3);
    send_re(1234, -567, 12, 1'b0);
    tick();
    chk("t4_eq_r",  bus.eq_r, 0);
    chk("t4_eq_i",  bus.eq_i, 0);
    chk("t4_csi",   bus.csi, 0);
    chk("t4_err",   bus.sc_err, 1);
    chk("t4_valid", bus.eq_valid, 1);

    // back-to-back stream with an overrun pair mid-stream
    for (int j = 0; j < 12; j++) begin
      bus.rx_r = 16'(100 * (j + 1));
      bus.rx_i = 16'(-50 * (j + 1));
      bus.rx_sc = 4'(j);
      bus.rx_last = (j == 11);
      bus.rx_valid = 1'b1;
      bus.valid_eqlz = (j == 5);
      bus.h_eqlz_1_r = 17'd777; bus.h_eqlz_1_i = 17'd555;
      bus.h_eqlz_2_r = 17'd333; bus.h_eqlz_2_i = 17'd111;
      tick();
      if (j == 5) chk("t5_ovr_pulse", bus.est_overrun, 1);
      if (j == 6) chk("t5_ovr_end", bus.est_overrun, 0);
    end
    drive_idle();
    chk("t5_ready_drop", bus.eq_ready, 0);
    chk("t5_last_early", bus.eq_last, 0);
    tick();
    chk("t5_last",  bus.eq_last, 1);
    chk("t5_eq_r",  bus.eq_r, 300);
    chk("t5_eq_i",  bus.eq_i, -150);
    chk("t5_csi",   bus.csi, 4096);
    fill_h(16384, 0);
    load_all(0);

    // reset with data in flight
    bus.rx_r = 16'(2000); bus.rx_i = '0; bus.rx_sc = 4'd0; bus.rx_valid = 1'b1;
    tick();
    bus.rx_r = 16'(4000); bus.rx_sc = 4'd1;
    tick();
    bus.rx_valid = 1'b0;
    chk("t6_pre_r", bus.eq_r, 500);
    rst = 1'b0;
    #1;
    chk("t6_valid", bus.eq_valid, 0);
    chk("t6_eq_r",  bus.eq_r, 0);
    chk("t6_eq_i",  bus.eq_i, 0);
    chk("t6_csi",   bus.csi, 0);
    chk("t6_last",  bus.eq_last, 0);
    chk("t6_err",   bus.sc_err, 0);
    chk("t6_ready", bus.eq_ready, 0);
    repeat (2) tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_no_valid", bus.eq_valid, 0);
      chk("t6_no_ready", bus.eq_ready, 0);
    end
    fill_h(8192, -8192);
    load_all(0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.valid_eqlz = ($urandom_range(0, 99) < 30);
      bus.h_eqlz_1_r = rand_h(); bus.h_eqlz_1_i = rand_h();
      bus.h_eqlz_2_r = rand_h(); bus.h_eqlz_2_i = rand_h();
      bus.rx_r = rand_rx(); bus.rx_i = rand_rx();
      bus.rx_sc = 4'($urandom_range(0, 13));
      bus.rx_valid = ($urandom_range(0, 99) < 70);
      bus.rx_last = ($urandom_range(0, 99) < 8);
      if (n == 1500) rst = 1'b0;
      if (n == 1503) rst = 1'b1;
      tick();
    end
    drive_idle();
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
